// File: rtl/bench_mux_pkg.sv
// rtl/bench_mux_pkg.sv - shared types, defaults and helpers for the output mux
package bench_mux_pkg;

    typedef enum logic [1:0] {
        LIVE  = 2'd0,
        PEND  = 2'd1,
        BLANK = 2'd2
    } mux_state_e;

    localparam int DEF_NUM_CH     = 8;
    localparam int DEF_DATA_W     = 8;
    localparam int DEF_STABLE_CYC = 3;
    localparam int DEF_BLANK_CYC  = 2;

    // Selector width for a channel count; never narrower than one bit
    function automatic int sel_width(input int num_ch);
        return (num_ch <= 2) ? 1 : $clog2(num_ch);
    endfunction

endpackage

// File: rtl/bench_ser_shift.sv
// rtl/bench_ser_shift.sv - parallel-load MSB-first serialiser for the output word
module bench_ser_shift #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [DATA_W-1:0] din,
    output logic              ser_out,
    output logic              busy
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // Busy while bits remain; the MSB of the shifter is the bit on the wire
    assign busy    = (cnt_q != '0);
    assign ser_out = busy & shreg_q[DATA_W-1];

    // Shift while busy; a load request is only honoured when idle
    always_comb begin
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        if (busy) begin
            shreg_d = {shreg_q[DATA_W-2:0], 1'b0};
            cnt_d   = cnt_q - CNT_W'(1);
        end else if (load) begin
            shreg_d = din;
            cnt_d   = CNT_W'(DATA_W);
        end
    end

    // Shifter and remaining-bit counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/bench_output_mux.sv
// rtl/bench_output_mux.sv - debounced, blanking channel selector for the benchmark outputs
module bench_output_mux
    import bench_mux_pkg::*;
#(
    parameter int  NUM_CH     = DEF_NUM_CH,
    parameter int  DATA_W     = DEF_DATA_W,
    parameter int  STABLE_CYC = DEF_STABLE_CYC,
    parameter int  BLANK_CYC  = DEF_BLANK_CYC,
    localparam int SEL_W      = sel_width(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    input  logic [SEL_W-1:0]         sel,
    input  logic                     freeze,
    input  logic                     ser_start,
    output logic [DATA_W-1:0]        data_out,
    output logic [SEL_W-1:0]         active_sel,
    output logic                     blank,
    output logic                     sel_err,
    output logic                     ser_out,
    output logic                     ser_busy
);

    localparam int CNT_W  = $clog2(STABLE_CYC + 1) + 1;
    localparam int BCNT_W = $clog2(BLANK_CYC + 1) + 1;
    // Counters compare against "limit minus one" so the current cycle counts
    localparam logic [CNT_W-1:0]  STABLE_M1 = CNT_W'(STABLE_CYC - 1);
    localparam logic [BCNT_W-1:0] BLANK_M1  = BCNT_W'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);
    localparam logic [SEL_W:0]    NUM_CH_V  = (SEL_W + 1)'(NUM_CH);

    mux_state_e        state_q, state_d;
    logic [SEL_W-1:0]  sync1_q, sync2_q;
    logic [SEL_W-1:0]  active_sel_q, active_sel_d;
    logic [SEL_W-1:0]  cand_q, cand_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [BCNT_W-1:0] bcnt_q, bcnt_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              blank_q, blank_d;
    logic              sel_err_q, sel_err_d;

    logic [DATA_W-1:0] ch_arr [NUM_CH];
    logic [SEL_W-1:0]  sel_s;
    logic              in_range;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign ch_arr[i] = ch_data[i*DATA_W +: DATA_W];
    end

    assign sel_s    = sync2_q;
    assign in_range = ({1'b0, sel_s} < NUM_CH_V);

    // All state: synchroniser, debounce FSM, committed channel and output register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= LIVE;
            sync1_q      <= '0;
            sync2_q      <= '0;
            active_sel_q <= '0;
            cand_q       <= '0;
            cnt_q        <= '0;
            bcnt_q       <= '0;
            data_out_q   <= '0;
            blank_q      <= 1'b0;
            sel_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync1_q      <= sel;
            sync2_q      <= sync1_q;
            active_sel_q <= active_sel_d;
            cand_q       <= cand_d;
            cnt_q        <= cnt_d;
            bcnt_q       <= bcnt_d;
            data_out_q   <= data_out_d;
            blank_q      <= blank_d;
            sel_err_q    <= sel_err_d;
        end
    end

    // Debounce: a new in-range selector must hold before commit; out-of-range is ignored
    always_comb begin
        state_d      = state_q;
        active_sel_d = active_sel_q;
        cand_d       = cand_q;
        cnt_d        = cnt_q;
        bcnt_d       = bcnt_q;
        case (state_q)
            LIVE: begin
                if (in_range && (sel_s != active_sel_q)) begin
                    cand_d  = sel_s;
                    cnt_d   = CNT_W'(1);
                    state_d = PEND;
                end
            end
            PEND: begin
                if (in_range) begin
                    if (sel_s == cand_q) begin
                        if (cnt_q >= STABLE_M1) begin
                            active_sel_d = cand_q;
                            bcnt_d       = '0;
                            state_d      = (BLANK_CYC > 0) ? BLANK : LIVE;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end else if (sel_s == active_sel_q) begin
                        state_d = LIVE;
                    end else begin
                        cand_d = sel_s;
                        cnt_d  = CNT_W'(1);
                    end
                end
            end
            BLANK: begin
                bcnt_d = bcnt_q + BCNT_W'(1);
                if (bcnt_q >= BLANK_M1) begin
                    state_d = LIVE;
                end
            end
            default: state_d = LIVE;
        endcase
    end

    // Output word: zero while blanking, otherwise track the committed channel unless frozen
    always_comb begin
        data_out_d = data_out_q;
        blank_d    = 1'b0;
        sel_err_d  = !in_range;
        if (state_q == BLANK) begin
            data_out_d = '0;
            blank_d    = 1'b1;
        end else if (!freeze) begin
            data_out_d = ch_arr[active_sel_q];
        end
    end

    bench_ser_shift #(
        .DATA_W (DATA_W)
    ) u_ser (
        .clk     (clk),
        .reset   (reset),
        .load    (ser_start),
        .din     (data_out_q),
        .ser_out (ser_out),
        .busy    (ser_busy)
    );

    assign data_out   = data_out_q;
    assign active_sel = active_sel_q;
    assign blank      = blank_q;
    assign sel_err    = sel_err_q;

endmodule

// File: tb/tb_bench_output_mux.sv
// tb/tb_bench_output_mux.sv - directed self-checking bench for bench_output_mux
module tb_bench_output_mux;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] ch8;
    logic [47:0] ch6;
    logic [2:0]  sel8, sel6;
    logic        freeze8, freeze6, start8, start6;

    logic [7:0]  dout8, dout6;
    logic [2:0]  asel8, asel6;
    logic        blank8, blank6, err8, err6, sout8, sout6, busy8, busy6;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bench_output_mux dut8 (
        .clk(clk), .reset(reset), .ch_data(ch8), .sel(sel8), .freeze(freeze8),
        .ser_start(start8), .data_out(dout8), .active_sel(asel8), .blank(blank8),
        .sel_err(err8), .ser_out(sout8), .ser_busy(busy8)
    );

    bench_output_mux #(.NUM_CH(6)) dut6 (
        .clk(clk), .reset(reset), .ch_data(ch6), .sel(sel6), .freeze(freeze6),
        .ser_start(start6), .data_out(dout6), .active_sel(asel6), .blank(blank6),
        .sel_err(err6), .ser_out(sout6), .ser_busy(busy6)
    );

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        sel8 = 3'd0; sel6 = 3'd0;
        freeze8 = 1'b0; freeze6 = 1'b0;
        start8 = 1'b0; start6 = 1'b0;
        #1;
        step(2);
        checks++;
        if ({dout8, asel8, blank8, err8, sout8, busy8} !== 15'd0) begin
            failures++;
            $display("FAIL reset8 outs=%h req=0", {dout8, asel8, blank8, err8, sout8, busy8});
        end
        checks++;
        if ({dout6, asel6, blank6, err6, sout6, busy6} !== 15'd0) begin
            failures++;
            $display("FAIL reset6 outs=%h req=0", {dout6, asel6, blank6, err6, sout6, busy6});
        end
        reset = 1'b0;
        step(1);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (dout8 !== 8'h10) begin
                failures++;
                $display("FAIL first_data cyc=%0d got=%h req=10", i, dout8);
            end
            checks++;
            if ({asel8, blank8, err8, sout8, busy8} !== 7'd0) begin
                failures++;
                $display("FAIL idle_outs cyc=%0d got=%h req=0", i, {asel8, blank8, err8, sout8, busy8});
            end
            step(1);
        end
    endtask

    task automatic test_switch;
        sel8 = 3'd5;
        step(4);
        checks++;
        if ({asel8, blank8, dout8} !== {3'd0, 1'b0, 8'h10}) begin
            failures++;
            $display("FAIL sw_pre got=%h req=%h", {asel8, blank8, dout8}, {3'd0, 1'b0, 8'h10});
        end
        step(1);
        checks++;
        if ({asel8, blank8, dout8} !== {3'd5, 1'b0, 8'h10}) begin
            failures++;
            $display("FAIL sw_commit got=%h req=%h", {asel8, blank8, dout8}, {3'd5, 1'b0, 8'h10});
        end
        for (int i = 0; i < 2; i++) begin
            step(1);
            checks++;
            if ({blank8, dout8} !== {1'b1, 8'h00}) begin
                failures++;
                $display("FAIL sw_blank cyc=%0d got=%h req=100", i, {blank8, dout8});
            end
        end
        step(1);
        checks++;
        if ({blank8, dout8} !== {1'b0, 8'h15}) begin
            failures++;
            $display("FAIL sw_post got=%h req=015", {blank8, dout8});
        end
    endtask

    task automatic test_debounce;
        // Short glitch to 2 for two cycles, then back to the committed 5
        sel8 = 3'd2;
        step(2);
        sel8 = 3'd5;
        for (int i = 0; i < 10; i++) begin
            step(1);
            checks++;
            if ({asel8, blank8, dout8} !== {3'd5, 1'b0, 8'h15}) begin
                failures++;
                $display("FAIL glitch cyc=%0d got=%h req=%h", i, {asel8, blank8, dout8}, {3'd5, 1'b0, 8'h15});
            end
        end
        // 3 for one cycle then 6: only 6 may commit, after three stable samples
        sel8 = 3'd3;
        step(1);
        sel8 = 3'd6;
        for (int i = 2; i <= 5; i++) begin
            step(1);
            checks++;
            if (asel8 !== 3'd5) begin
                failures++;
                $display("FAIL retarget cyc=%0d got=%0d req=5", i, asel8);
            end
        end
        step(1);
        checks++;
        if (asel8 !== 3'd6) begin
            failures++;
            $display("FAIL retarget_commit got=%0d req=6", asel8);
        end
        step(3);
        checks++;
        if ({blank8, dout8} !== {1'b0, 8'h16}) begin
            failures++;
            $display("FAIL retarget_data got=%h req=016", {blank8, dout8});
        end
    endtask

    task automatic test_sel_err;
        sel6 = 3'd7;
        step(2);
        checks++;
        if (err6 !== 1'b0) begin
            failures++;
            $display("FAIL err_early got=%b req=0", err6);
        end
        step(1);
        for (int i = 0; i < 6; i++) begin
            checks++;
            if ({err6, asel6, blank6, dout6} !== {1'b1, 3'd0, 1'b0, 8'h10}) begin
                failures++;
                $display("FAIL err_hold cyc=%0d got=%h req=%h", i, {err6, asel6, blank6, dout6}, {1'b1, 3'd0, 1'b0, 8'h10});
            end
            step(1);
        end
        sel6 = 3'd2;
        step(3);
        checks++;
        if ({err6, asel6} !== {1'b0, 3'd0}) begin
            failures++;
            $display("FAIL err_drop got=%h req=0", {err6, asel6});
        end
        step(2);
        checks++;
        if (asel6 !== 3'd2) begin
            failures++;
            $display("FAIL err_commit got=%0d req=2", asel6);
        end
        step(1);
        checks++;
        if ({blank6, dout6} !== {1'b1, 8'h00}) begin
            failures++;
            $display("FAIL err_blank got=%h req=100", {blank6, dout6});
        end
        step(2);
        checks++;
        if ({blank6, dout6} !== {1'b0, 8'h12}) begin
            failures++;
            $display("FAIL err_data got=%h req=012", {blank6, dout6});
        end
    endtask

    task automatic test_freeze;
        freeze8 = 1'b1;
        ch8[55:48] = 8'hAA;
        step(3);
        checks++;
        if (dout8 !== 8'h16) begin
            failures++;
            $display("FAIL frz_hold got=%h req=16", dout8);
        end
        sel8 = 3'd1;
        step(5);
        checks++;
        if (asel8 !== 3'd1) begin
            failures++;
            $display("FAIL frz_commit got=%0d req=1", asel8);
        end
        step(2);
        checks++;
        if ({blank8, dout8} !== {1'b1, 8'h00}) begin
            failures++;
            $display("FAIL frz_blank got=%h req=100", {blank8, dout8});
        end
        step(3);
        checks++;
        if ({blank8, dout8} !== {1'b0, 8'h00}) begin
            failures++;
            $display("FAIL frz_zero got=%h req=000", {blank8, dout8});
        end
        freeze8 = 1'b0;
        ch8[55:48] = 8'h16;
        step(1);
        checks++;
        if (dout8 !== 8'h11) begin
            failures++;
            $display("FAIL frz_release got=%h req=11", dout8);
        end
    endtask

    task automatic test_serial;
        logic [7:0] w;
        w = 8'hA5;
        ch8[15:8] = w;
        step(1);
        checks++;
        if (dout8 !== 8'hA5) begin
            failures++;
            $display("FAIL ser_word got=%h req=a5", dout8);
        end
        start8 = 1'b1;
        step(1);
        start8 = 1'b0;
        ch8[15:8] = 8'h00;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if ({busy8, sout8} !== {1'b1, w[7-i]}) begin
                failures++;
                $display("FAIL ser_bit%0d got=%b req=%b", i, {busy8, sout8}, {1'b1, w[7-i]});
            end
            if (i == 3) start8 = 1'b1;
            step(1);
            start8 = 1'b0;
        end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({busy8, sout8} !== 2'b00) begin
                failures++;
                $display("FAIL ser_idle cyc=%0d got=%b req=00", i, {busy8, sout8});
            end
            step(1);
        end
        ch8[15:8] = 8'hFF;
        step(1);
        start8 = 1'b1;
        step(1);
        start8 = 1'b0;
        step(3);
        checks++;
        if ({busy8, sout8} !== 2'b11) begin
            failures++;
            $display("FAIL ser_cyc4 got=%b req=11", {busy8, sout8});
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({busy8, sout8, dout8, asel8, blank8} !== 14'd0) begin
            failures++;
            $display("FAIL ser_reset got=%h req=0", {busy8, sout8, dout8, asel8, blank8});
        end
        step(1);
        reset = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) ch8[i*8 +: 8] = 8'(8'h10 + i);
        for (int i = 0; i < 6; i++) ch6[i*8 +: 8] = 8'(8'h10 + i);
        test_reset();
        test_sel_err();
        test_switch();
        test_debounce();
        test_freeze();
        test_serial();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
